// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - per-channel switch debouncer with level and rise/fall event outputs
// Optional input synchronizer: define DEBOUNCE_SYNC_EN.
module debounce_multi #(
  parameter int                  CHANNELS  = 4,
  parameter int                  COUNT_MAX = 5000,
  parameter int                  CNT_W     = 16,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam logic [0:0]       ST_STABLE   = 1'b0;
  localparam logic [0:0]       ST_COUNTING = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(COUNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [CHANNELS-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = sig_in;
`endif

  logic [0:0]       state_q [CHANNELS];
  logic [0:0]       state_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] deb_q, deb_d;
  logic [CHANNELS-1:0] rise_d, fall_d;
  logic [CHANNELS-1:0] accept;
  logic                any_d;

  always_comb begin
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    accept = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (en && (s[i] != deb_q[i])) begin
            // A one-cycle window accepts on the very edge the mismatch is seen.
            if (COUNT_MAX == 1) begin
              accept[i] = 1'b1;
            end else begin
              state_d[i] = ST_COUNTING;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        ST_COUNTING: begin
          // A matching sample clears the window even while frozen.
          if (s[i] == deb_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (en && (cnt_q[i] == CNT_LAST)) begin
            accept[i] = 1'b1;
          end else if (en) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
      if (accept[i]) begin
        deb_d[i]   = s[i];
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
        state_d[i] = ST_STABLE;
        cnt_d[i]   = '0;
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      deb_q      <= RESET_VAL;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q      <= deb_d;
      rise       <= rise_d;
      fall       <= fall_d;
      any_change <= any_d;
    end
  end

  assign debounced = deb_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed bench for debounce_multi with a cycle-level reference model
// Latency expectations follow DEBOUNCE_SYNC_EN when it is defined for the build.
module tb_debounce_multi;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int CM  = 8;
  localparam int LAT = CM + SYNC_LAT;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] sig;
  logic [3:0] deb_a, rise_a, fall_a, deb_b, rise_b, fall_b;
  logic       any_a, any_b;
  logic       chk_on;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_multi #(.CHANNELS(4), .COUNT_MAX(CM), .CNT_W(16), .RESET_VAL(4'h0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig),
    .debounced(deb_a), .rise(rise_a), .fall(fall_a), .any_change(any_a)
  );

  debounce_multi #(.CHANNELS(4), .COUNT_MAX(1), .CNT_W(4), .RESET_VAL(4'hF)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig),
    .debounced(deb_b), .rise(rise_b), .fall(fall_b), .any_change(any_b)
  );

  // Model: each channel counts enabled edges on which its sample disagrees with
  // the accepted level; agreement zeroes it, reaching the window length flips the level.
  int         cmax [2] = '{CM, 1};
  logic [3:0] rv   [2] = '{4'h0, 4'hF};
  logic [3:0] m_deb [2], m_rise [2], m_fall [2], q1 [2], q2 [2];
  logic       m_any [2];
  int         m_cnt [2][4];
  logic [3:0] prev_sig;
  logic       prev_en, prev_rst;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_deb[d] = rv[d]; m_rise[d] = '0; m_fall[d] = '0; m_any[d] = 1'b0;
      q1[d] = rv[d]; q2[d] = rv[d];
      for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [3:0] smp;
      smp = (SYNC_LAT > 0) ? q2[d] : prev_sig;
      m_rise[d] = '0;
      m_fall[d] = '0;
      for (int c = 0; c < 4; c++) begin
        if (smp[c] == m_deb[d][c]) begin
          m_cnt[d][c] = 0;
        end else if (prev_en) begin
          m_cnt[d][c] = m_cnt[d][c] + 1;
          if (m_cnt[d][c] == cmax[d]) begin
            m_deb[d][c] = smp[c];
            if (smp[c]) m_rise[d][c] = 1'b1;
            else        m_fall[d][c] = 1'b1;
            m_cnt[d][c] = 0;
          end
        end
      end
      m_any[d] = |(m_rise[d] | m_fall[d]);
      q2[d] = q1[d];
      q1[d] = prev_sig;
    end
  endtask

  initial begin
    prev_sig = '0; prev_en = 1'b1; prev_rst = 1'b1;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst || prev_rst) model_reset();
      else                 model_step();
      prev_sig = sig; prev_en = en; prev_rst = rst;
      if (chk_on) begin
        check("a_debounced", deb_a, m_deb[0]);
        check("a_rise", rise_a, m_rise[0]);
        check("a_fall", fall_a, m_fall[0]);
        check("a_any", {3'b0, any_a}, {3'b0, m_any[0]});
        check("b_debounced", deb_b, m_deb[1]);
        check("b_rise", rise_b, m_rise[1]);
        check("b_fall", fall_b, m_fall[1]);
        check("b_any", {3'b0, any_b}, {3'b0, m_any[1]});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sig = 4'b0000; chk_on = 1'b0;
    step(2);
    check("rst_deb_a", deb_a, 4'b0000);
    check("rst_rise_a", rise_a, 4'b0000);
    check("rst_any_a", {3'b0, any_a}, 4'b0000);
    check("rst_deb_b", deb_b, 4'b1111);
    rst = 1'b0;
    chk_on = 1'b1;
    step(3);

    // clean press on ch0
    sig = 4'b0001;
    step(LAT - 1);
    check("press_early_deb", deb_a, 4'b0000);
    check("press_early_rise", rise_a, 4'b0000);
    step(1);
    check("press_deb", deb_a, 4'b0001);
    check("press_rise", rise_a, 4'b0001);
    check("press_any", {3'b0, any_a}, 4'b0001);
    check("press_fall", fall_a, 4'b0000);
    step(1);
    check("press_rise_gone", rise_a, 4'b0000);
    check("press_deb_b", deb_b, 4'b0001);

    // 7-cycle glitch on ch1, then a full window
    sig = 4'b0011;
    step(CM - 1);
    sig = 4'b0001;
    step(LAT + 2);
    check("glitch_deb", deb_a, 4'b0001);
    sig = 4'b0011;
    step(LAT);
    check("glitch_after_rise", rise_a, 4'b0010);
    check("glitch_after_deb", deb_a, 4'b0011);
    step(2);

    // staggered and simultaneous acceptance
    sig = 4'b0111;
    step(3);
    sig = 4'b1111;
    step(LAT - 3);
    check("stagger_rise2", rise_a, 4'b0100);
    step(3);
    check("stagger_rise3", rise_a, 4'b1000);
    step(2);
    sig = 4'b0011;
    step(LAT);
    check("simul_fall", fall_a, 4'b1100);
    check("simul_any", {3'b0, any_a}, 4'b0001);
    step(2);

    // en low for edges 3..6 of a ch0 fall
    sig = 4'b0010;
    step(2);
    en = 1'b0;
    step(4);
    en = 1'b1;
    step(LAT - 3);
    check("freeze_early_deb", deb_a, 4'b0011);
    check("freeze_early_fall", fall_a, 4'b0000);
    step(1);
    check("freeze_fall", fall_a, 4'b0001);
    check("freeze_deb", deb_a, 4'b0010);
    step(2);

    // revert while frozen clears the partial count
    sig = 4'b0011;
    step(3);
    en = 1'b0;
    sig = 4'b0010;
    step(4);
    sig = 4'b0011;
    step(4);
    check("revert_frozen_deb", deb_a, 4'b0010);
    en = 1'b1;
    step(CM - 1);
    check("revert_early_deb", deb_a, 4'b0010);
    step(1);
    check("revert_rise", rise_a, 4'b0001);
    step(2);

    // reset mid-count
    sig = 4'b0111;
    step(5);
    rst = 1'b1;
    #1;
    check("midrst_deb_a", deb_a, 4'b0000);
    check("midrst_deb_b", deb_b, 4'b1111);
    step(1);
    rst = 1'b0;
    step(LAT - 1);
    check("postrst_early_deb", deb_a, 4'b0000);
    step(1);
    check("postrst_deb", deb_a, 4'b0111);
    check("postrst_rise", rise_a, 4'b0111);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
